// File: rtl/h264_chroma_recon_if.sv
// h264_chroma_recon_if: stream bundle between the chroma residual source and the reconstruction block
//   NEWLINE    start of MB line, clears block counters
//   STROBEI    residual row valid (taken only while READYO=1)
//   DATAI      4x 9-bit signed residuals, pixel n in [9n+8:9n]
//   BASEI      4x 8-bit prediction base, pixel n in [8n+7:8n]
//   READYO     reconstruction can take a row this cycle
//   STROBEO    RECO valid
//   RECO       reconstructed row, pixel n in [8n+7:8n]
//   XXO        {crcb, quad[0]} tag of RECO
//   FBSTROBEO  FEEDBO valid
//   FEEDBO     right-column pixel of the finished 4x4 block, rows 0..3
//   TOPSTROBEO TOPO valid
//   TOPO       last row of a bottom block, for next-line top store
//   ERRO       sticky dropped-row flag
//   SATCNT     clipped-pixel count (zero unless the counter is built in)
interface h264_chroma_recon_if;
    logic        NEWLINE;
    logic        STROBEI;
    logic [35:0] DATAI;
    logic [31:0] BASEI;
    logic        READYO;
    logic        STROBEO;
    logic [31:0] RECO;
    logic [1:0]  XXO;
    logic        FBSTROBEO;
    logic [7:0]  FEEDBO;
    logic        TOPSTROBEO;
    logic [31:0] TOPO;
    logic        ERRO;
    logic [15:0] SATCNT;
    modport master (
        output NEWLINE, STROBEI, DATAI, BASEI,
        input  READYO, STROBEO, RECO, XXO, FBSTROBEO, FEEDBO, TOPSTROBEO, TOPO, ERRO, SATCNT
    );
    modport slave (
        input  NEWLINE, STROBEI, DATAI, BASEI,
        output READYO, STROBEO, RECO, XXO, FBSTROBEO, FEEDBO, TOPSTROBEO, TOPO, ERRO, SATCNT
    );
endinterface

// File: rtl/h264_chroma_recon.sv
// h264_chroma_recon: adds residual rows to the prediction base, clips to pixels, streams rows out
// and returns each 4x4 block's right column (left-neighbour feedback) and bottom-block last rows.
//   CLK2    clock, rising edge
//   RESETN  synchronous reset, active low
//   bus     h264_chroma_recon_if.slave: residual/base input stream, reconstructed row stream,
//           feedback byte stream, top-row stream, error flag, clip counter
//   FB_GAP  idle cycles between a block's last row and its first feedback byte (0..3)
// Optional: define RECON_SATCNT_EN to build the saturating clipped-pixel counter on SATCNT.
module h264_chroma_recon #(
    parameter int FB_GAP = 0
) (
    input logic CLK2,
    input logic RESETN,
    h264_chroma_recon_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        SEND0 = 3'd4,
        SEND1 = 3'd5,
        SEND2 = 3'd6,
        SEND3 = 3'd7
    } fb_state_e;

    fb_state_e       state_q, state_d;
    logic [1:0]      gap_q, gap_d;
    logic [4:0]      cnt_q, cnt_d, tag;   // {crcb, quad[1:0], row[1:0]}
    logic            accept, pend;
    logic            s1_v_q;
    logic [4:0]      s1_tag_q;
    logic [3:0][9:0] sum_d, s1_sum_q;
    logic [3:0][7:0] pix, reco_q, top_q, shadow_q, shadow_d;
    logic [2:0][7:0] col_q;
    logic            strobeo_q, topstrobe_q, fb_q, fb_d, err_q;
    logic [1:0]      xxo_q;
    logic [7:0]      feed_q, feed_d;

    // Row 3 sits in stage 1: its stage-2 cycle latches the shadow column and starts feedback.
    assign pend       = s1_v_q & (s1_tag_q[1:0] == 2'd3);
    assign bus.READYO = (state_q == IDLE) & ~pend;
    assign accept     = bus.STROBEI & bus.READYO;
    assign tag        = bus.NEWLINE ? 5'd0 : cnt_q;
    assign cnt_d      = accept ? tag + 5'd1 : tag;

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            sum_d[n] = {bus.DATAI[9*n+8], bus.DATAI[9*n +: 9]} + {2'b00, bus.BASEI[8*n +: 8]};
            pix[n]   = s1_sum_q[n][9] ? 8'h00 : s1_sum_q[n][8] ? 8'hFF : s1_sum_q[n][7:0];
        end
        shadow_d = pend ? {pix[3], col_q} : shadow_q;
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE: if (pend) begin
                state_d = (FB_GAP == 0) ? SEND0 : WAIT;
                gap_d   = 2'(FB_GAP - 1);
            end
            WAIT: begin
                gap_d = gap_q - 2'd1;
                if (gap_q == 2'd0) state_d = SEND0;
            end
            SEND0:   state_d = SEND1;
            SEND1:   state_d = SEND2;
            SEND2:   state_d = SEND3;
            default: state_d = IDLE;
        endcase
        // SEND states carry the shadow row index in their low bits.
        fb_d   = state_d[2];
        feed_d = fb_d ? shadow_d[state_d[1:0]] : 8'h00;
    end

    always_ff @(posedge CLK2) begin
        if (!RESETN) begin
            state_q     <= IDLE;
            gap_q       <= '0;
            cnt_q       <= '0;
            s1_v_q      <= 1'b0;
            s1_tag_q    <= '0;
            s1_sum_q    <= '0;
            reco_q      <= '0;
            top_q       <= '0;
            shadow_q    <= '0;
            col_q       <= '0;
            strobeo_q   <= 1'b0;
            topstrobe_q <= 1'b0;
            fb_q        <= 1'b0;
            err_q       <= 1'b0;
            xxo_q       <= '0;
            feed_q      <= '0;
        end else begin
            cnt_q  <= cnt_d;
            s1_v_q <= accept;
            if (accept) begin
                s1_tag_q <= tag;
                s1_sum_q <= sum_d;
            end
            strobeo_q   <= s1_v_q;
            topstrobe_q <= pend & s1_tag_q[3];
            if (s1_v_q) begin
                reco_q <= pix;
                xxo_q  <= {s1_tag_q[4], s1_tag_q[2]};
            end
            if (s1_v_q & ~pend) col_q[s1_tag_q[1:0]] <= pix[3];
            if (pend & s1_tag_q[3]) top_q <= pix;
            shadow_q <= shadow_d;
            state_q  <= state_d;
            gap_q    <= gap_d;
            fb_q     <= fb_d;
            feed_q   <= feed_d;
            if (bus.STROBEI & ~bus.READYO) err_q <= 1'b1;
        end
    end

`ifdef RECON_SATCNT_EN
    logic [15:0] sat_q;
    logic [2:0]  sat_inc;
    logic [16:0] sat_sum;

    always_comb begin
        sat_inc = '0;
        for (int n = 0; n < 4; n++) sat_inc = sat_inc + 3'(s1_sum_q[n][9] | s1_sum_q[n][8]);
        sat_sum = {1'b0, sat_q} + (s1_v_q ? 17'(sat_inc) : 17'd0);
    end

    always_ff @(posedge CLK2) begin
        if (!RESETN || bus.NEWLINE) sat_q <= '0;
        else sat_q <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end

    assign bus.SATCNT = sat_q;
`else
    assign bus.SATCNT = 16'd0;
`endif

    assign bus.STROBEO    = strobeo_q;
    assign bus.RECO       = reco_q;
    assign bus.XXO        = xxo_q;
    assign bus.FBSTROBEO  = fb_q;
    assign bus.FEEDBO     = feed_q;
    assign bus.TOPSTROBEO = topstrobe_q;
    assign bus.TOPO       = top_q;
    assign bus.ERRO       = err_q;
endmodule

// File: tb/tb_h264_chroma_recon.sv
// tb_h264_chroma_recon: directed scoreboard bench for h264_chroma_recon
module tb_h264_chroma_recon;
    localparam int FBG = 0;

    logic CLK2 = 1'b0;
    logic RESETN = 1'b0;

    h264_chroma_recon_if bus();

    h264_chroma_recon #(.FB_GAP(FBG)) dut (
        .CLK2(CLK2),
        .RESETN(RESETN),
        .bus(bus.slave)
    );

    always #5 CLK2 = ~CLK2;

    typedef struct {
        logic [31:0] reco;
        logic [1:0]  xxo;
        logic        top;
        int          due;
    } row_t;

    typedef struct {
        logic [7:0] v;
        int         due;
    } fb_t;

    row_t       rq[$];
    fb_t        fq[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         sat_model = 0;
    logic [4:0] exp_cnt = '0;
    logic [7:0] mcol[4];

    function automatic logic [31:0] recon(input logic [35:0] d, input logic [31:0] b);
        logic [31:0] r;
        logic [8:0]  x;
        int          s;
        for (int n = 0; n < 4; n++) begin
            x = d[9*n +: 9];
            s = int'($signed(x)) + int'(b[8*n +: 8]);
            r[8*n +: 8] = (s < 0) ? 8'h00 : (s > 255) ? 8'hFF : 8'(s);
        end
        return r;
    endfunction

    function automatic int nclip(input logic [35:0] d, input logic [31:0] b);
        logic [8:0] x;
        int         s;
        int         c = 0;
        for (int n = 0; n < 4; n++) begin
            x = d[9*n +: 9];
            s = int'($signed(x)) + int'(b[8*n +: 8]);
            if (s < 0 || s > 255) c++;
        end
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", name, obs, exp, cyc);
        end
    endtask

    task automatic mon();
        row_t e;
        fb_t  f;
        if (bus.STROBEO) begin
            if (rq.size() == 0) chk("rows_pending", 32'(rq.size()), 32'd1);
            else begin
                e = rq.pop_front();
                chk("reco", bus.RECO, e.reco);
                chk("xxo", 32'(bus.XXO), 32'(e.xxo));
                chk("top_strobe", 32'(bus.TOPSTROBEO), 32'(e.top));
                if (e.top) chk("topo", bus.TOPO, e.reco);
                chk("reco_cycle", 32'(cyc), 32'(e.due));
            end
        end else chk("top_strobe_idle", 32'(bus.TOPSTROBEO), 32'd0);
        if (bus.FBSTROBEO) begin
            if (fq.size() == 0) chk("fb_pending", 32'(fq.size()), 32'd1);
            else begin
                f = fq.pop_front();
                chk("feedbo", 32'(bus.FEEDBO), 32'(f.v));
                chk("fb_cycle", 32'(cyc), 32'(f.due));
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK2);
        cyc++;
        @(negedge CLK2);
        mon();
    endtask

    task automatic send_row(input logic [35:0] d, input logic [31:0] b, input logic nl);
        int          g = 0;
        logic [4:0]  t;
        logic [31:0] r;
        row_t        e;
        fb_t         f;
        while (!bus.READYO && g < 40) begin
            tick();
            g++;
        end
        chk("ready_wait", 32'(bus.READYO), 32'd1);
        t = nl ? 5'd0 : exp_cnt;
        exp_cnt = t + 5'd1;
        r = recon(d, b);
        sat_model += nclip(d, b);
        e.reco = r;
        e.xxo  = {t[4], t[2]};
        e.top  = (t[1:0] == 2'd3) && t[3];
        e.due  = cyc + 2;
        rq.push_back(e);
        mcol[t[1:0]] = r[31:24];
        if (t[1:0] == 2'd3)
            for (int k = 0; k < 4; k++) begin
                f.v   = mcol[k];
                f.due = cyc + 2 + FBG + k;
                fq.push_back(f);
            end
        bus.NEWLINE = nl;
        bus.STROBEI = 1'b1;
        bus.DATAI   = d;
        bus.BASEI   = b;
        tick();
        bus.STROBEI = 1'b0;
        bus.NEWLINE = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [35:0] rnd36();
        return {4'($urandom), 32'($urandom)};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          n;
        int          t3;
        logic [31:0] sat_exp;
        bus.NEWLINE = 1'b0;
        bus.STROBEI = 1'b0;
        bus.DATAI   = '0;
        bus.BASEI   = '0;
        drain(2);
        chk("rst_readyo", 32'(bus.READYO), 32'd1);
        chk("rst_strobeo", 32'(bus.STROBEO), 32'd0);
        chk("rst_reco", bus.RECO, 32'd0);
        chk("rst_xxo", 32'(bus.XXO), 32'd0);
        chk("rst_fbstrobeo", 32'(bus.FBSTROBEO), 32'd0);
        chk("rst_feedbo", 32'(bus.FEEDBO), 32'd0);
        chk("rst_topo", bus.TOPO, 32'd0);
        chk("rst_erro", 32'(bus.ERRO), 32'd0);
        chk("rst_satcnt", 32'(bus.SATCNT), 32'd0);
        RESETN = 1'b1;
        tick();

        // zero residual block: pass-through of the base, then READYO low window
        for (int i = 0; i < 4; i++) send_row(36'd0, 32'h80808080, 1'b0);
        n = 0;
        while (!bus.READYO && n < 20) begin
            n++;
            tick();
        end
        chk("ready_low_cycles", 32'(n), 32'(5 + FBG));

        // clipping row followed by three ordinary rows
        send_row({9'd20, 9'h1EC, 9'h1FB, 9'd20}, 32'hFF0010F0, 1'b0);
        for (int i = 0; i < 3; i++) send_row(rnd36(), $urandom, 1'b0);
        drain(8);
`ifdef RECON_SATCNT_EN
        sat_exp = 32'(sat_model);
`else
        sat_exp = 32'd0;
`endif
        chk("satcnt", 32'(bus.SATCNT), sat_exp);

        // full MB started by NEWLINE on its first row
        send_row(rnd36(), $urandom, 1'b1);
        for (int i = 1; i < 32; i++) send_row(rnd36(), $urandom, 1'b0);
        drain(8);

        // protocol error: row driven while READYO=0 is dropped
        for (int i = 0; i < 4; i++) send_row(rnd36(), $urandom, 1'b0);
        chk("ready_low_err", 32'(bus.READYO), 32'd0);
        bus.STROBEI = 1'b1;
        bus.DATAI   = rnd36();
        bus.BASEI   = $urandom;
        tick();
        bus.STROBEI = 1'b0;
        chk("erro_set", 32'(bus.ERRO), 32'd1);
        for (int i = 0; i < 2; i++) send_row(rnd36(), $urandom, 1'b0);

        // NEWLINE alone mid-block restarts the count
        bus.NEWLINE = 1'b1;
        tick();
        bus.NEWLINE = 1'b0;
        exp_cnt = '0;
        for (int i = 0; i < 4; i++) send_row(rnd36(), $urandom, 1'b0);
        drain(8);
        chk("erro_sticky", 32'(bus.ERRO), 32'd1);

        // reset during SEND1
        for (int i = 0; i < 4; i++) send_row(rnd36(), $urandom, 1'b0);
        t3 = cyc - 1;
        while (cyc < t3 + 3 + FBG) tick();
        chk("send1_active", 32'(bus.FBSTROBEO), 32'd1);
        RESETN = 1'b0;
        tick();
        chk("rst_mid_fb", 32'(bus.FBSTROBEO), 32'd0);
        chk("rst_mid_ready", 32'(bus.READYO), 32'd1);
        chk("rst_mid_erro", 32'(bus.ERRO), 32'd0);
        rq.delete();
        fq.delete();
        exp_cnt = '0;
        sat_model = 0;
        RESETN = 1'b1;

        // fresh block after reset: Cb quad 0, right column 10,20,30,40
        send_row({9'd0, 27'($urandom)}, {8'h10, 24'($urandom)}, 1'b0);
        send_row({9'd0, 27'($urandom)}, {8'h20, 24'($urandom)}, 1'b0);
        send_row({9'd0, 27'($urandom)}, {8'h30, 24'($urandom)}, 1'b0);
        send_row({9'd0, 27'($urandom)}, {8'h40, 24'($urandom)}, 1'b0);
        drain(12);
        chk("rows_left", 32'(rq.size()), 32'd0);
        chk("fb_left", 32'(fq.size()), 32'd0);
        chk("erro_final", 32'(bus.ERRO), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
